// File: rtl/operand_packer_if.sv
// Byte-pair input stream and packed A/B vector output of operand_packer.
// master = source/consumer side, slave = the packer itself.
interface operand_packer_if #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int CNTW  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_a;
    logic [DW-1:0]         in_b;
    logic                  in_last;
    logic [LANES*DW-1:0]   A;
    logic [LANES*DW-1:0]   B;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNTW-1:0]       vec_count;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, A, B, out_valid, vec_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, A, B, out_valid, vec_count
    );
endinterface

// File: rtl/operand_packer.sv
// operand_packer: packs LANES (a,b) byte pairs into wide A/B vectors, double-buffered.
// Define PACKER_PAD_EN to let in_last complete a short vector with zero-filled upper lanes.
//
// state   | meaning
// FILLING | collecting pairs into the fill buffer, in_ready=1
// HOLD    | fill buffer holds a complete vector waiting for the output slot, in_ready=0
module operand_packer #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int CNTW  = 16
) (
    input logic             clk,
    input logic             rst,
    operand_packer_if.slave bus
);
    localparam int VW   = LANES * DW;
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LANES - 1);

    localparam logic [0:0] S_FILLING = 1'b0;
    localparam logic [0:0] S_HOLD    = 1'b1;

    logic [0:0]      state;
    logic [IDXW-1:0] idx;
    logic [VW-1:0]   fill_a;
    logic [VW-1:0]   fill_b;
    logic [VW-1:0]   merged_a;
    logic [VW-1:0]   merged_b;
    logic [VW-1:0]   out_a;
    logic [VW-1:0]   out_b;
    logic            out_valid_q;
    logic [CNTW-1:0] vec_count_q;
    logic            in_ready;
    logic            in_xfer;
    logic            out_xfer;
    logic            slot_free;
    logic            complete;
    logic            load;

    assign in_ready  = (state == S_FILLING);
    assign in_xfer   = bus.in_valid && in_ready;
    assign out_xfer  = out_valid_q && bus.out_ready;
    assign slot_free = !out_valid_q || out_xfer;

`ifdef PACKER_PAD_EN
    assign complete = in_xfer && ((idx == IDX_LAST) || bus.in_last);
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
    assign complete = in_xfer && (idx == IDX_LAST);
`endif

    assign load = slot_free && (complete || (state == S_HOLD));

    // Fill buffer with the current pair written into lane idx (and upper lanes cleared on a short vector)
    always_comb begin
        merged_a = fill_a;
        merged_b = fill_b;
        for (int k = 0; k < LANES; k++) begin
            if (k == int'(idx)) begin
                merged_a[k*DW +: DW] = bus.in_a;
                merged_b[k*DW +: DW] = bus.in_b;
            end
`ifdef PACKER_PAD_EN
            else if ((k > int'(idx)) && bus.in_last) begin
                merged_a[k*DW +: DW] = '0;
                merged_b[k*DW +: DW] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILLING;
            idx         <= '0;
            fill_a      <= '0;
            fill_b      <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_valid_q <= 1'b0;
            vec_count_q <= '0;
        end else begin
            if (in_xfer) begin
                fill_a <= merged_a;
                fill_b <= merged_b;
                idx    <= complete ? '0 : idx + 1'b1;
            end

            if (complete && !slot_free) begin
                state <= S_HOLD;
            end else if ((state == S_HOLD) && slot_free) begin
                state <= S_FILLING;
            end

            // A held vector comes from the fill buffer; a just-completed one bypasses it
            if (load) begin
                out_a       <= (state == S_HOLD) ? fill_a : merged_a;
                out_b       <= (state == S_HOLD) ? fill_b : merged_b;
                out_valid_q <= 1'b1;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end

            if (out_xfer) begin
                vec_count_q <= vec_count_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.A         = out_a;
    assign bus.B         = out_b;
    assign bus.out_valid = out_valid_q;
    assign bus.vec_count = vec_count_q;
endmodule
